// File: rtl/out_reg_uart_tx_pkg.sv
// uart_pkg: shared types, constants and helpers for the output-register UART.
//
// Contents:
//   seq_state_t     - character sequencer states (parent module)
//   tx_state_t      - byte serializer states (uart_tx_byte)
//   CHAR_CR/CHAR_LF - line terminator characters sent after each word
//   clks_per_bit()  - clock cycles per UART bit, truncated
//   nibble_to_ascii - 4-bit value to uppercase ASCII hex digit
//
// Build option: UART_PARITY_EN adds the TX_PARITY state (8E1 framing).

package uart_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_LOAD,
        SEQ_WAIT
    } seq_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        // 'A' is 0x41, so digits 10..15 sit at 0x37 + value
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/out_reg_uart_tx_if.sv
// out_reg_uart_tx_if: write port and status flags between the CPU output
// register logic (master) and the UART hex transmitter (slave).
//
// Signals:
//   wr_en     - one-cycle write strobe
//   wr_data   - word to transmit
//   full      - transmit FIFO holds FIFO_DEPTH words
//   busy      - transmitter has work in flight
//   overflow  - sticky: a write was dropped because the FIFO was full

interface out_reg_uart_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  busy;
    logic                  overflow;

    modport master (
        output wr_en, wr_data,
        input  full, busy, overflow
    );

    modport slave (
        input  wr_en, wr_data,
        output full, busy, overflow
    );
endinterface

// File: rtl/out_reg_uart_tx_byte.sv
// uart_tx_byte: serializes one byte per start pulse as start bit, 8 data
// bits LSB first, (optional even parity bit,) stop bit.
//
// Ports:
//   clk, a_reset_n - clock, asynchronous active-low reset
//   start          - one-cycle request to send tx_byte
//   tx_byte        - byte to send, sampled when start is high
//   done           - one-cycle pulse near the end of the stop bit
//   busy           - a frame is on the line
//   uart_tx        - registered serial output, idles high
//
// Build option: UART_PARITY_EN inserts the even parity bit before the stop bit.
//
// done fires four clocks before the stop bit ends. That lead covers the
// parent's sequencing pipeline, so the next start is already waiting when
// the stop bit expires and consecutive frames are gap-free. A start received
// during the stop bit is remembered in 'pending'. CLKS_PER_BIT must be >= 4.

module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       a_reset_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       done,
    output logic       busy,
    output logic       uart_tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(CLKS_PER_BIT - 4);

    tx_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          pending, pending_nxt;
    logic          line_nxt;
    logic          bit_end;
`ifdef UART_PARITY_EN
    logic          par, par_nxt;
`endif

    // State and datapath registers; uart_tx is loaded from the next-state
    // line value so the pin is a flop that changes with the state.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            pending <= 1'b0;
            uart_tx <= 1'b1;
`ifdef UART_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            pending <= pending_nxt;
            uart_tx <= line_nxt;
`ifdef UART_PARITY_EN
            par     <= par_nxt;
`endif
        end
    end

    // Next-state logic: each state lasts CLKS_PER_BIT clocks per bit.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        pending_nxt = pending;
        done        = 1'b0;
        bit_end     = (cnt == CNT_LAST);
`ifdef UART_PARITY_EN
        par_nxt     = par;
`endif
        case (state)
            TX_IDLE: begin
                if (start) begin
                    state_nxt = TX_START;
                    cnt_nxt   = '0;
                    shift_nxt = tx_byte;
`ifdef UART_PARITY_EN
                    par_nxt   = ^tx_byte;
`endif
                end
            end
            TX_START: begin
                cnt_nxt = cnt + CW'(1);
                if (bit_end) begin
                    state_nxt   = TX_DATA;
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                end
            end
            TX_DATA: begin
                cnt_nxt = cnt + CW'(1);
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_nxt = TX_PARITY;
`else
                        state_nxt = TX_STOP;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        shift_nxt   = shift >> 1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                cnt_nxt = cnt + CW'(1);
                if (bit_end) begin
                    state_nxt = TX_STOP;
                    cnt_nxt   = '0;
                end
            end
`endif
            TX_STOP: begin
                cnt_nxt = cnt + CW'(1);
                done    = (cnt == CNT_DONE);
                // The shift register is idle during the stop bit, so the
                // next byte can be parked there early.
                if (start) begin
                    shift_nxt   = tx_byte;
                    pending_nxt = 1'b1;
`ifdef UART_PARITY_EN
                    par_nxt     = ^tx_byte;
`endif
                end
                if (bit_end) begin
                    cnt_nxt     = '0;
                    pending_nxt = 1'b0;
                    state_nxt   = (start || pending) ? TX_START : TX_IDLE;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase

        case (state_nxt)
            TX_START:  line_nxt = 1'b0;
            TX_DATA:   line_nxt = shift_nxt[0];
`ifdef UART_PARITY_EN
            TX_PARITY: line_nxt = par_nxt;
`endif
            default:   line_nxt = 1'b1;
        endcase
    end

    assign busy = (state != TX_IDLE);

endmodule

// File: rtl/out_reg_uart_tx.sv
// out_reg_uart_tx: captures words written to the CPU output register,
// queues them in a FIFO and sends each as uppercase ASCII hex (MSB nibble
// first) followed by CR LF on a UART line.
//
// Ports:
//   clk        - system clock
//   a_reset_n  - asynchronous active-low reset
//   wr_bus     - slave side of out_reg_uart_tx_if (wr_en/wr_data in,
//                full/busy/overflow out)
//   uart_tx    - serial line to the USB-UART, idles high
//
// Build option: UART_PARITY_EN selects 8E1 framing in uart_tx_byte.
//
// Timing from an idle start: push at edge N, pop into the word register at
// N+1, byte handed to the serializer at N+2, start bit on the pin at N+3.

module out_reg_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               a_reset_n,
    out_reg_uart_tx_if.slave   wr_bus,
    output logic               uart_tx
);

    localparam int CPB     = clks_per_bit(CLK_FREQ, BAUD);
    localparam int NIBBLES = DATA_WIDTH / 4;
    localparam int NCHARS  = NIBBLES + 2;
    localparam int IW      = $clog2(NCHARS);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [IW-1:0] LAST_CHAR = IW'(NCHARS - 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  push, pop, full, empty;
    logic                  overflow_q;

    seq_state_t            seq, seq_nxt;
    logic [IW-1:0]         char_idx, char_idx_nxt;
    logic [DATA_WIDTH-1:0] word_q, word_nxt;
    logic [7:0]            byte_q, byte_nxt;
    logic                  start_q, start_nxt;
    logic                  byte_done, byte_busy;

    function automatic logic [7:0] char_at(input logic [DATA_WIDTH-1:0] w,
                                           input logic [IW-1:0] idx);
        logic [DATA_WIDTH-1:0] sh;
        logic [7:0]            c;
        sh = w >> (4 * (NIBBLES - 1 - int'(idx)));
        if (idx == IW'(NIBBLES))
            c = CHAR_CR;
        else if (idx == LAST_CHAR)
            c = CHAR_LF;
        else
            c = nibble_to_ascii(sh[3:0]);
        return c;
    endfunction

    // full comes from the registered count, so a same-cycle pop never
    // makes room for a write.
    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = wr_bus.wr_en && !full;

    assign wr_bus.full     = full;
    assign wr_bus.overflow = overflow_q;
    assign wr_bus.busy     = (seq != SEQ_IDLE) || !empty || byte_busy;

    // FIFO storage is not reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_bus.wr_data;
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_bus.wr_en && full)
                overflow_q <= 1'b1;
        end
    end

    // Sequencer registers: state, word being sent, character index and the
    // registered byte/start handed to the serializer.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            seq      <= SEQ_IDLE;
            char_idx <= '0;
            word_q   <= '0;
            byte_q   <= '0;
            start_q  <= 1'b0;
        end else begin
            seq      <= seq_nxt;
            char_idx <= char_idx_nxt;
            word_q   <= word_nxt;
            byte_q   <= byte_nxt;
            start_q  <= start_nxt;
        end
    end

    // Sequencer: pop a word, then issue its characters one at a time,
    // advancing on each serializer done pulse.
    always_comb begin
        seq_nxt      = seq;
        char_idx_nxt = char_idx;
        word_nxt     = word_q;
        byte_nxt     = byte_q;
        start_nxt    = 1'b0;
        pop          = 1'b0;
        case (seq)
            SEQ_IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    word_nxt     = mem[rd_ptr];
                    char_idx_nxt = '0;
                    seq_nxt      = SEQ_LOAD;
                end
            end
            SEQ_LOAD: begin
                byte_nxt  = char_at(word_q, char_idx);
                start_nxt = 1'b1;
                seq_nxt   = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                if (byte_done) begin
                    if (char_idx == LAST_CHAR) begin
                        seq_nxt = SEQ_IDLE;
                    end else begin
                        char_idx_nxt = char_idx + IW'(1);
                        seq_nxt      = SEQ_LOAD;
                    end
                end
            end
            default: seq_nxt = SEQ_IDLE;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CPB)
    ) u_tx_byte (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .start     (start_q),
        .tx_byte   (byte_q),
        .done      (byte_done),
        .busy      (byte_busy),
        .uart_tx   (uart_tx)
    );

endmodule

// File: tb/tb_out_reg_uart_tx.sv
// tb_out_reg_uart_tx: drives out_reg_uart_tx through its write interface.
// Every accepted word is expanded by a reference model into its ASCII hex
// characters, which are queued. A UART receiver pops that queue for each
// frame it sees on the line and compares the two. A reduced bit period
// (1 MHz / 115200 -> 8 clocks) keeps the run short.
// Build option: UART_PARITY_EN (11-bit frames, parity bit checked).

module tb_out_reg_uart_tx;

    localparam int DATA_WIDTH = 16;
    localparam int CLK_FREQ   = 1000000;
    localparam int BAUD       = 115200;
    localparam int FIFO_DEPTH = 4;
    localparam int CPB        = CLK_FREQ / BAUD;
`ifdef UART_PARITY_EN
    localparam int FB         = 11;
`else
    localparam int FB         = 10;
`endif
    localparam int NIB        = DATA_WIDTH / 4;
    localparam int NCH        = NIB + 2;
    localparam int WORD_CLKS  = NCH * FB * CPB;

    logic clk = 1'b0;
    logic a_reset_n = 1'b0;
    logic uart_tx;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] exp_q[$];
    int         starts_q[$];

    out_reg_uart_tx_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    out_reg_uart_tx #(
        .DATA_WIDTH (DATA_WIDTH),
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .wr_bus    (bus),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a word becomes its hex digits, MSB nibble first, then CR LF.
    task automatic pushWord(input logic [DATA_WIDTH-1:0] w);
        int nib;
        for (int i = 0; i < NIB; i++) begin
            nib = int'((w >> (4 * (NIB - 1 - i))) & 16'hF);
            exp_q.push_back((nib < 10) ? 8'(48 + nib) : 8'(55 + nib));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic applyStimulus(input logic [DATA_WIDTH-1:0] w, output int edge_cyc);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = w;
        @(posedge clk);
        #1;
        edge_cyc = cyc;
    endtask

    task automatic idleBus();
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int k = 0;
        while ((bus.busy !== 1'b0 || exp_q.size() != 0) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        checkOutput({name, "_chars_left"}, exp_q.size(), 0);
        checkOutput({name, "_busy_end"}, bus.busy, 1'b0);
    endtask

    task automatic checkGaps(input string name, input int nframes, input int first);
        int bad = 0;
        checkOutput({name, "_frames"}, starts_q.size(), nframes);
        if (starts_q.size() > 0)
            checkOutput({name, "_first_start"}, starts_q[0], first);
        for (int i = 1; i < starts_q.size(); i++)
            if (starts_q[i] - starts_q[i-1] != FB * CPB)
                bad++;
        checkOutput({name, "_gap_errors"}, bad, 0);
    endtask

    // Line monitor: detect a start bit, sample each bit mid-period, then
    // pop the scoreboard and compare. A reset anywhere in the frame aborts it.
    initial begin : monitor
        logic [7:0] rx;
        logic [7:0] exp_ch;
        logic       start_bit, stop_bit, aborted;
`ifdef UART_PARITY_EN
        logic       par_bit;
`endif
        int         wait_n;
        forever begin
            @(negedge clk);
            if (a_reset_n === 1'b1 && uart_tx === 1'b0) begin
                starts_q.push_back(cyc);
                rx        = '0;
                start_bit = 1'b1;
                stop_bit  = 1'b0;
                aborted   = 1'b0;
`ifdef UART_PARITY_EN
                par_bit   = 1'b0;
`endif
                for (int b = 0; b < FB && !aborted; b++) begin
                    wait_n = (b == 0) ? CPB / 2 : CPB;
                    repeat (wait_n) begin
                        @(negedge clk);
                        if (a_reset_n !== 1'b1) aborted = 1'b1;
                    end
                    if (b == 0)           start_bit = uart_tx;
                    else if (b <= 8)      rx[b-1]   = uart_tx;
                    else if (b == FB - 1) stop_bit  = uart_tx;
`ifdef UART_PARITY_EN
                    else                  par_bit   = uart_tx;
`endif
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("[TB] FAIL unexpected_char: got 0x%0h, expected no character (cycle %0d)", rx, cyc);
                    end else begin
                        exp_ch = exp_q.pop_front();
                        checkOutput("char", rx, exp_ch);
                        checkOutput("start_bit", start_bit, 1'b0);
                        checkOutput("stop_bit", stop_bit, 1'b1);
`ifdef UART_PARITY_EN
                        checkOutput("parity_bit", par_bit, ^exp_ch);
`endif
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        n_bad++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "[TB] time limit reached");
    end

    initial begin : stimulus
        int e0, e1, lows, nw, target;
        logic [DATA_WIDTH-1:0] w;

        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        a_reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_uart_tx", uart_tx, 1'b1);
        checkOutput("rst_busy", bus.busy, 1'b0);
        checkOutput("rst_full", bus.full, 1'b0);
        checkOutput("rst_overflow", bus.overflow, 1'b0);
        a_reset_n = 1'b1;
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        checkOutput("idle_line_low_cycles", lows, 0);

        $display("[TB] single word 16'h1A2F");
        starts_q.delete();
        pushWord(16'h1A2F);
        applyStimulus(16'h1A2F, e0);
        idleBus();
        while (cyc < e0 + 2 + WORD_CLKS) @(negedge clk);
        checkOutput("single_busy_last_clk", bus.busy, 1'b1);
        @(negedge clk);
        checkOutput("single_busy_dropped", bus.busy, 1'b0);
        checkGaps("single", NCH, e0 + 3);
        waitDrain("single");

        $display("[TB] boundary nibbles 0000 / FFFF back-to-back");
        starts_q.delete();
        pushWord(16'h0000);
        pushWord(16'hFFFF);
        applyStimulus(16'h0000, e0);
        applyStimulus(16'hFFFF, e1);
        idleBus();
        waitDrain("boundary");
        checkGaps("boundary", 2 * NCH, e0 + 3);

        $display("[TB] overflow: six consecutive writes");
        starts_q.delete();
        e0 = 0;
        for (int i = 1; i <= 6; i++) begin
            // Capacity from idle is FIFO_DEPTH plus the word popped on the first edge.
            if (i <= FIFO_DEPTH + 1) pushWord(DATA_WIDTH'(i));
            applyStimulus(DATA_WIDTH'(i), e1);
            if (i == 1) e0 = e1;
            if (i == 4) checkOutput("ovf_full_after_4", bus.full, 1'b0);
            if (i == 5) begin
                checkOutput("ovf_full_after_5", bus.full, 1'b1);
                checkOutput("ovf_flag_after_5", bus.overflow, 1'b0);
            end
            if (i == 6) checkOutput("ovf_flag_after_6", bus.overflow, 1'b1);
        end
        idleBus();
        waitDrain("overflow");
        checkGaps("overflow", 5 * NCH, e0 + 3);
        checkOutput("ovf_sticky", bus.overflow, 1'b1);

        $display("[TB] randomized bursts");
        for (int b = 0; b < 6; b++) begin
            nw = int'($urandom_range(1, FIFO_DEPTH));
            for (int k = 0; k < nw; k++) begin
                w = DATA_WIDTH'($urandom);
                pushWord(w);
                applyStimulus(w, e1);
                idleBus();
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
            waitDrain("random");
        end
        checkOutput("ovf_sticky_after_random", bus.overflow, 1'b1);

        $display("[TB] reset during second character");
        starts_q.delete();
        pushWord(16'hC0DE);
        applyStimulus(16'hC0DE, e0);
        idleBus();
        target = e0 + 3 + FB * CPB + CPB + 3 * CPB + 2;
        while (cyc < target - 1) @(negedge clk);
        @(posedge clk);
        #2;
        a_reset_n = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("midrst_uart_tx", uart_tx, 1'b1);
        checkOutput("midrst_busy", bus.busy, 1'b0);
        checkOutput("midrst_full", bus.full, 1'b0);
        checkOutput("midrst_overflow", bus.overflow, 1'b0);
        checkOutput("midrst_frames_started", starts_q.size(), 2);
        repeat (10) @(negedge clk);
        a_reset_n = 1'b1;
        starts_q.delete();
        pushWord(16'hBEEF);
        applyStimulus(16'hBEEF, e0);
        idleBus();
        waitDrain("beef");
        checkGaps("beef", NCH, e0 + 3);

`ifdef UART_PARITY_EN
        $display("[TB] parity word 16'h0007");
        pushWord(16'h0007);
        applyStimulus(16'h0007, e0);
        idleBus();
        waitDrain("parity");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/out_reg_uart_tx.md
Name: out_reg_uart_tx

Overview:
- Consumer end of the CPU output register.
- Captures each word the processor writes to its output register and queues it in a small FIFO.
- Serializes each word to the host over UART as uppercase ASCII hex followed by CR LF.
- Sits beside out_reg in fpga_top: wr_en is driven by out_reg_en and wr_data by the bus value into out_reg; uart_tx goes to the USB-UART pin.

Parameters:
- DATA_WIDTH, 16, word width; must be a multiple of 4.
- CLK_FREQ, 100000000, clk frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- FIFO_DEPTH, 4, number of queued words; must be a power of 2, minimum 2.

Ports:
- clk  input  1  system clock (clk100MHz).
- a_reset_n  input  1  asynchronous active-low reset.
- wr_en  input  1  one-cycle write strobe from the controller.
- wr_data  input  DATA_WIDTH  word to transmit.
- full  output  1  FIFO holds FIFO_DEPTH words.
- busy  output  1  FSM not IDLE or FIFO not empty.
- overflow  output  1  sticky flag: a write was dropped.
- uart_tx  output  1  serial line, idles high.

Behaviour:
- Reset (async, a_reset_n=0):
  - uart_tx=1, full=0, busy=0, overflow=0.
  - FIFO emptied, FSM to IDLE.
  - Applies immediately, including mid-frame; the partial character is abandoned and the line returns high.
- Bit period: CLKS_PER_BIT = CLK_FREQ/BAUD, truncated (868 at defaults). Every bit, including start and stop, lasts exactly CLKS_PER_BIT clocks.
- FIFO:
  - Push when wr_en=1 and full=0.
  - wr_en while full: word dropped, overflow set to 1 and held until reset.
  - full is derived from the registered count; a push is rejected when full even if a pop occurs in the same cycle.
  - A pop in the same cycle as a push to a non-full FIFO is legal; count is unchanged.
- Character sequence per word:
  - DATA_WIDTH/4 nibbles, MSB nibble first.
  - Nibble 0-9 maps to 0x30-0x39; A-F maps to 0x41-0x46.
  - Then 0x0D, then 0x0A.
  - 6 characters per word at the default width.
- Frame: start bit (0), 8 data bits LSB first, stop bit (1). No gap between characters or between words when the FIFO is non-empty.
- FSM states:
  - IDLE: FIFO not empty -> pop into word register, char_idx=0, go to LOAD.
  - LOAD: select character char_idx into shift register -> START.
  - START: uart_tx=0 for CLKS_PER_BIT -> DATA.
  - DATA: shift 8 bits, bit counter 0..7 -> STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT; then if char_idx is the last character -> IDLE, else char_idx+1 -> LOAD.
- Latency: for wr_en sampled at edge N with FSM IDLE and FIFO empty:
  - pop occurs at edge N+1;
  - LOAD at N+2;
  - uart_tx registered low at edge N+3.
- uart_tx is driven from a flop; no combinational path to the pin.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between the last data bit and the stop bit, via an added PARITY state. Frame is 11 bits.
- Undefined: 8N1, 10-bit frame, no PARITY state present.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum;
  - ASCII constants CHAR_CR=8'h0D and CHAR_LF=8'h0A;
  - a function computing CLKS_PER_BIT from CLK_FREQ and BAUD;
  - nibble-to-ASCII function.
- Sub-module uart_tx_byte holds the START/DATA/STOP(/PARITY) serializer and baud counter.
  - Interface: start/byte in, done pulse out.
- The parent holds the FIFO, the word register and the character sequencer.

Test Plan:
- Reset: a_reset_n=0 -> uart_tx=1, busy=0, full=0, overflow=0; after release, line stays high with no writes.
- Single word: wr_en with 16'h1A2F -> bytes 0x31,0x41,0x32,0x46,0x0D,0x0A, each bit 868 clocks; start edge 3 clocks after the wr_en edge; busy drops after 52080+3 clocks.
- Boundary nibbles: 16'h0000 then 16'hFFFF written back-to-back -> "0000\r\n" then "FFFF\r\n" with no idle gap; FIFO drains to busy=0.
- Overflow: wr_en held for 6 consecutive cycles with 16'h0001..16'h0006 -> words 1-5 transmitted in order; 0x0006 dropped; full=1 after the 5th edge; overflow=1 and stays 1.
- Reset mid-frame: a_reset_n low during the DATA state of the second character -> uart_tx=1 in the same cycle, FIFO empty; a subsequent write of 16'hBEEF transmits "BEEF\r\n" cleanly.
- Parity (UART_PARITY_EN): 16'h0007 -> '7' (0x37) frame carries parity bit 1 and '0' (0x30) frames carry parity bit 0; frame is 11 bit periods.
